// File: rtl/josh_pkg.sv
// Shared game-state encodings for the J.O.S.H. Jump core; used by the physics top and the renderers.
// Pure type definitions: no latency, no flow control.
package josh_pkg;

  typedef enum logic [1:0] {
    MENU = 2'd0,
    ARM  = 2'd1,
    PLAY = 2'd2,
    OVER = 2'd3
  } state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running modulo-TICK_DIV counter producing a one-cycle frame pulse.
// tick is registered and high while the count sits at TICK_DIV-1; it never stalls.
module tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(TICK_DIV - 2);

  logic [CW-1:0] cnt;

  // tick is decoded one count early so it lines up with cnt == LAST as a register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
      tick <= (cnt == PRE);
    end
  end

endmodule

// File: rtl/josh_physics.sv
// J.O.S.H. Jump game core: menu/arm/play/over FSM, gravity-flip player physics, collision death, saturating score.
// One physics step per frame tick in PLAY, visible the cycle after the tick; inputs are sampled every cycle, no backpressure.
module josh_physics
  import josh_pkg::*;
#(
  parameter int Y_BITS     = 8,
  parameter int Y_MIN      = 6,
  parameter int Y_MAX      = 100,
  parameter int DUDE_H     = 4,
  parameter int STEP       = 1,
  parameter int TICK_DIV   = 833333,
  parameter int SCORE_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  grav,
  input  logic                  solid_down,
  input  logic                  solid_up,
  input  logic                  solid_front,
  output logic [1:0]            state,
  output logic                  tick,
  output logic [Y_BITS-1:0]     dude_y,
  output logic                  grav_eff,
  output logic                  grounded,
  output logic                  endgame,
  output logic [SCORE_BITS-1:0] score
);

  localparam int Y_TOP = Y_MAX - DUDE_H;
  localparam int YW    = Y_BITS + 1;

  localparam logic [YW-1:0]     MIN_E  = YW'(Y_MIN);
  localparam logic [YW-1:0]     TOP_E  = YW'(Y_TOP);
  localparam logic [YW-1:0]     STEP_E = YW'(STEP);
  localparam logic [Y_BITS-1:0] Y_FLOOR = Y_BITS'(Y_MIN);

  state_t st;

  logic          g_new;
  logic          blocked;
  logic          at_lim;
  logic [YW-1:0] y_e;
  logic [YW-1:0] tgt;

  assign state = st;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Candidate move, one bit wider than dude_y so neither direction can wrap before clamping.
  always_comb begin
    g_new   = grounded ? grav : grav_eff;
    y_e     = {1'b0, dude_y};
    tgt     = y_e;
    blocked = 1'b0;
    at_lim  = 1'b0;
    if (g_new) begin
      tgt     = (y_e + STEP_E >= TOP_E) ? TOP_E : y_e + STEP_E;
      blocked = solid_up;
      at_lim  = (tgt == TOP_E);
    end else begin
      tgt     = (y_e <= MIN_E + STEP_E) ? MIN_E : y_e - STEP_E;
      blocked = solid_down;
      at_lim  = (tgt == MIN_E);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= MENU;
      dude_y   <= Y_FLOOR;
      grav_eff <= 1'b0;
      grounded <= 1'b1;
      score    <= '0;
      endgame  <= 1'b0;
    end else begin
      endgame <= 1'b0;
      case (st)
        MENU: begin
          if (go) begin
            st       <= ARM;
            dude_y   <= Y_FLOOR;
            grav_eff <= 1'b0;
            grounded <= 1'b1;
            score    <= '0;
          end
        end
        ARM: begin
          if (!go) st <= PLAY;
        end
        PLAY: begin
          if (tick) begin
            // a front collision ends the frame before any movement or scoring
            if (solid_front) begin
              st      <= OVER;
              endgame <= 1'b1;
            end else begin
              grav_eff <= g_new;
              if (!blocked) dude_y <= tgt[Y_BITS-1:0];
              grounded <= blocked | at_lim;
              if (score != '1) score <= score + 1'b1;
            end
          end
        end
        OVER: begin
          if (go) st <= MENU;
        end
        default: st <= MENU;
      endcase
    end
  end

endmodule
